// File: rtl/regfile_access_sequencer.sv
// regfile_access_sequencer
// Shares one single-port register file between write-back (single writes)
// and operand fetch (two-source reads). Writes have priority over reads. A
// read request is turned into two back-to-back reads on the port, and both
// operands are returned together.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   i_wr_valid/o_wr_ready          write-back request handshake
//   i_wr_addr, i_wr_data           write destination and data
//   i_rd_req_valid/o_rd_req_ready  operand-fetch request handshake
//   i_rs1, i_rs2                   source register indices
//   o_rd_rsp_valid/i_rd_rsp_ready  operand response handshake
//   o_rs1_data, o_rs2_data         operand values (x0 reads as zero)
//   o_rf_we, o_rf_addr, o_rf_wdata register file port controls
//   i_rf_rdata                     register file read data (one cycle after addr)
module regfile_access_sequencer #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_req_valid,
  output logic                  o_rd_req_ready,
  input  logic [ADDR_WIDTH-1:0] i_rs1,
  input  logic [ADDR_WIDTH-1:0] i_rs2,
  output logic                  o_rd_rsp_valid,
  input  logic                  i_rd_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rs1_data,
  output logic [DATA_WIDTH-1:0] o_rs2_data,
  output logic                  o_rf_we,
  output logic [ADDR_WIDTH-1:0] o_rf_addr,
  output logic [DATA_WIDTH-1:0] o_rf_wdata,
  input  logic [DATA_WIDTH-1:0] i_rf_rdata
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RS1  = 3'd2,
    RS2  = 3'd3,
    CAP  = 3'd4,
    RESP = 3'd5
  } state_e;

  state_e                state_q,    state_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q,  wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q,  wr_data_d;
  logic [ADDR_WIDTH-1:0] rs1_q,      rs1_d;
  logic [ADDR_WIDTH-1:0] rs2_q,      rs2_d;
  logic [DATA_WIDTH-1:0] rs1_data_q, rs1_data_d;
  logic [DATA_WIDTH-1:0] rs2_data_q, rs2_data_d;

  logic idle;
  logic wr_fire;
  logic rd_fire;

  // Handshake readies: only IDLE accepts, and a pending write blocks the read.
  always_comb begin
    idle           = (state_q == IDLE);
    o_wr_ready     = idle && !rst;
    o_rd_req_ready = idle && !rst && !i_wr_valid;
    wr_fire        = i_wr_valid && o_wr_ready;
    rd_fire        = i_rd_req_valid && o_rd_req_ready;
  end

  // Next-state and capture logic.
  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;

    case (state_q)
      IDLE: begin
        if (wr_fire) begin
          wr_addr_d = i_wr_addr;
          wr_data_d = i_wr_data;
          state_d   = WR;
        end else if (rd_fire) begin
          rs1_d   = i_rs1;
          rs2_d   = i_rs2;
          state_d = RS1;
        end
      end
      WR:  state_d = IDLE;
      RS1: state_d = RS2;
      RS2: begin
        // rdata now reflects the rs1 address presented in RS1.
        rs1_data_d = (rs1_q == '0) ? '0 : i_rf_rdata;
        state_d    = CAP;
      end
      CAP: begin
        rs2_data_d = (rs2_q == '0) ? '0 : i_rf_rdata;
        state_d    = RESP;
      end
      RESP: begin
        if (i_rd_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (rst) begin
      state_d    = IDLE;
      wr_addr_d  = '0;
      wr_data_d  = '0;
      rs1_d      = '0;
      rs2_d      = '0;
      rs1_data_d = '0;
      rs2_data_d = '0;
    end
  end

  // State and data registers.
  always_ff @(posedge clk) begin
    state_q    <= state_d;
    wr_addr_q  <= wr_addr_d;
    wr_data_q  <= wr_data_d;
    rs1_q      <= rs1_d;
    rs2_q      <= rs2_d;
    rs1_data_q <= rs1_data_d;
    rs2_data_q <= rs2_data_d;
  end

  // Port drive decoded from registered state; we is gated by rst so a write
  // caught by reset never reaches the register file.
  always_comb begin
    o_rf_addr  = '0;
    o_rf_wdata = '0;
    o_rf_we    = 1'b0;
    case (state_q)
      WR: begin
        o_rf_addr  = wr_addr_q;
        o_rf_wdata = wr_data_q;
        o_rf_we    = (wr_addr_q != '0) && !rst;
      end
      RS1:     o_rf_addr = rs1_q;
      RS2:     o_rf_addr = rs2_q;
      CAP:     o_rf_addr = rs2_q;
      default: o_rf_addr = '0;
    endcase
    o_rd_rsp_valid = (state_q == RESP);
    o_rs1_data     = rs1_data_q;
    o_rs2_data     = rs2_data_q;
  end

endmodule

// File: tb/tb_regfile_access_sequencer.sv
// Directed bench for regfile_access_sequencer with a single-port register
// file model (synchronous write, registered read).
module tb_regfile_access_sequencer;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_wr_valid, o_wr_ready;
  logic [AW-1:0] i_wr_addr;
  logic [DW-1:0] i_wr_data;
  logic          i_rd_req_valid, o_rd_req_ready;
  logic [AW-1:0] i_rs1, i_rs2;
  logic          o_rd_rsp_valid, i_rd_rsp_ready;
  logic [DW-1:0] o_rs1_data, o_rs2_data;
  logic          o_rf_we;
  logic [AW-1:0] o_rf_addr;
  logic [DW-1:0] o_rf_wdata, i_rf_rdata;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mem [32];
  logic [DW-1:0] rf_rdata_q;
  logic          force_ones;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (o_rf_we) mem[o_rf_addr] <= o_rf_wdata;
    rf_rdata_q <= mem[o_rf_addr];
  end
  assign i_rf_rdata = force_ones ? '1 : rf_rdata_q;

  regfile_access_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
    .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .i_rd_req_valid(i_rd_req_valid), .o_rd_req_ready(o_rd_req_ready),
    .i_rs1(i_rs1), .i_rs2(i_rs2),
    .o_rd_rsp_valid(o_rd_rsp_valid), .i_rd_rsp_ready(i_rd_rsp_ready),
    .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data),
    .o_rf_we(o_rf_we), .o_rf_addr(o_rf_addr), .o_rf_wdata(o_rf_wdata),
    .i_rf_rdata(i_rf_rdata)
  );

  // Move to one time unit after the next rising edge.
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    adv();
    adv();
    @(negedge clk);
    checks++; if (o_wr_ready !== 1'b0) begin failures++; $display("FAIL rst_wr_ready got=%0b want=0", o_wr_ready); end
    checks++; if (o_rd_req_ready !== 1'b0) begin failures++; $display("FAIL rst_rd_req_ready got=%0b want=0", o_rd_req_ready); end
    checks++; if (o_rd_rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%0b want=0", o_rd_rsp_valid); end
    checks++; if (o_rf_we !== 1'b0 || o_rf_addr !== '0 || o_rf_wdata !== '0) begin failures++; $display("FAIL rst_rf_port got we=%0b addr=%0d wdata=%h want 0/0/0", o_rf_we, o_rf_addr, o_rf_wdata); end
    checks++; if (o_rs1_data !== '0 || o_rs2_data !== '0) begin failures++; $display("FAIL rst_rs_data got %h %h want 0 0", o_rs1_data, o_rs2_data); end
    rst = 1'b0;
    adv();
    @(negedge clk);
    checks++; if (o_wr_ready !== 1'b1 || o_rd_req_ready !== 1'b1) begin failures++; $display("FAIL post_rst_readies got wr=%0b rd=%0b want 1 1", o_wr_ready, o_rd_req_ready); end
    adv();
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    i_wr_valid = 1'b1; i_wr_addr = a; i_wr_data = d;
    @(negedge clk);
    checks++; if (o_wr_ready !== 1'b1) begin failures++; $display("FAIL wr_ready r%0d got=%0b want=1", a, o_wr_ready); end
    adv();
    i_wr_valid = 1'b0;
    @(negedge clk);
    checks++; if (o_rf_we !== (a != '0)) begin failures++; $display("FAIL wr_we r%0d got=%0b want=%0b", a, o_rf_we, (a != '0)); end
    checks++; if (o_rf_addr !== a || o_rf_wdata !== d) begin failures++; $display("FAIL wr_port r%0d got addr=%0d data=%h want %0d %h", a, o_rf_addr, o_rf_wdata, a, d); end
    checks++; if (o_wr_ready !== 1'b0) begin failures++; $display("FAIL wr_busy_ready r%0d got=%0b want=0", a, o_wr_ready); end
    adv();
    @(negedge clk);
    checks++; if (o_rf_we !== 1'b0 || o_wr_ready !== 1'b1) begin failures++; $display("FAIL wr_done r%0d got we=%0b ready=%0b want 0 1", a, o_rf_we, o_wr_ready); end
    adv();
  endtask

  // Read with stall cycles of i_rd_rsp_ready=0 after the response appears.
  task automatic do_read(input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                         input logic [DW-1:0] e1, input logic [DW-1:0] e2,
                         input int stall);
    i_rd_rsp_ready = (stall == 0);
    i_rd_req_valid = 1'b1; i_rs1 = r1; i_rs2 = r2;
    @(negedge clk);
    checks++; if (o_rd_req_ready !== 1'b1) begin failures++; $display("FAIL rd_req_ready (%0d,%0d) got=%0b want=1", r1, r2, o_rd_req_ready); end
    adv();
    i_rd_req_valid = 1'b0;
    @(negedge clk);
    checks++; if (o_rf_addr !== r1 || o_rd_rsp_valid !== 1'b0) begin failures++; $display("FAIL rd_addr1 got addr=%0d valid=%0b want %0d 0", o_rf_addr, o_rd_rsp_valid, r1); end
    adv();
    @(negedge clk);
    checks++; if (o_rf_addr !== r2 || o_rf_we !== 1'b0) begin failures++; $display("FAIL rd_addr2 got addr=%0d we=%0b want %0d 0", o_rf_addr, o_rf_we, r2); end
    adv();
    @(negedge clk);
    checks++; if (o_rd_rsp_valid !== 1'b0) begin failures++; $display("FAIL rd_early_valid got=%0b want=0", o_rd_rsp_valid); end
    adv();
    @(negedge clk);
    checks++; if (o_rd_rsp_valid !== 1'b1) begin failures++; $display("FAIL rd_valid_lat3 got=%0b want=1", o_rd_rsp_valid); end
    checks++; if (o_rs1_data !== e1 || o_rs2_data !== e2) begin failures++; $display("FAIL rd_data (%0d,%0d) got %h %h want %h %h", r1, r2, o_rs1_data, o_rs2_data, e1, e2); end
    for (int k = 0; k < stall; k++) begin
      adv();
      @(negedge clk);
      checks++; if (o_rd_rsp_valid !== 1'b1 || o_rs1_data !== e1 || o_rs2_data !== e2) begin failures++; $display("FAIL stall_hold cyc%0d got v=%0b %h %h want 1 %h %h", k, o_rd_rsp_valid, o_rs1_data, o_rs2_data, e1, e2); end
      checks++; if (o_wr_ready !== 1'b0 || o_rd_req_ready !== 1'b0) begin failures++; $display("FAIL stall_readies cyc%0d got %0b %0b want 0 0", k, o_wr_ready, o_rd_req_ready); end
    end
    i_rd_rsp_ready = 1'b1;
    adv();
    @(negedge clk);
    checks++; if (o_rd_rsp_valid !== 1'b0 || o_wr_ready !== 1'b1) begin failures++; $display("FAIL rd_back_idle got valid=%0b wr_ready=%0b want 0 1", o_rd_rsp_valid, o_wr_ready); end
    adv();
  endtask

  task automatic test_fill_and_read();
    for (int i = 1; i < 32; i++) do_write(AW'(i), DW'(i + 1));
    do_read(5'd1, 5'd2, 32'd2, 32'd3, 0);
    do_read(5'd31, 5'd31, 32'd32, 32'd32, 0);
  endtask

  task automatic test_write_priority();
    i_wr_valid = 1'b1; i_wr_addr = 5'd5; i_wr_data = 32'hDEADBEEF;
    i_rd_req_valid = 1'b1; i_rs1 = 5'd5; i_rs2 = 5'd0;
    @(negedge clk);
    checks++; if (o_wr_ready !== 1'b1 || o_rd_req_ready !== 1'b0) begin failures++; $display("FAIL prio_readies got wr=%0b rd=%0b want 1 0", o_wr_ready, o_rd_req_ready); end
    adv();
    i_wr_valid = 1'b0;
    @(negedge clk);
    checks++; if (o_rf_we !== 1'b1 || o_rd_req_ready !== 1'b0) begin failures++; $display("FAIL prio_wr_cycle got we=%0b rd_ready=%0b want 1 0", o_rf_we, o_rd_req_ready); end
    adv();
    do_read(5'd5, 5'd0, 32'hDEADBEEF, 32'd0, 0);
  endtask

  task automatic test_x0();
    do_write(5'd0, 32'h1234);
    force_ones = 1'b1;
    do_read(5'd0, 5'd0, 32'd0, 32'd0, 0);
    force_ones = 1'b0;
  endtask

  task automatic test_stall();
    do_read(5'd3, 5'd4, 32'd4, 32'd5, 10);
  endtask

  task automatic test_reset_in_write();
    i_wr_valid = 1'b1; i_wr_addr = 5'd7; i_wr_data = 32'hA5A5A5A5;
    @(negedge clk);
    adv();
    i_wr_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (o_rf_we !== 1'b0) begin failures++; $display("FAIL rst_wr_we got=%0b want=0", o_rf_we); end
    checks++; if (o_wr_ready !== 1'b0 || o_rd_req_ready !== 1'b0) begin failures++; $display("FAIL rst_wr_readies got %0b %0b want 0 0", o_wr_ready, o_rd_req_ready); end
    adv();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (o_rd_rsp_valid !== 1'b0 || o_rs1_data !== '0 || o_rs2_data !== '0) begin failures++; $display("FAIL rst_wr_rsp got v=%0b %h %h want 0 0 0", o_rd_rsp_valid, o_rs1_data, o_rs2_data); end
    checks++; if (o_rf_we !== 1'b0 || o_rf_addr !== '0 || o_rf_wdata !== '0) begin failures++; $display("FAIL rst_wr_port got we=%0b addr=%0d wdata=%h want 0 0 0", o_rf_we, o_rf_addr, o_rf_wdata); end
    adv();
    do_read(5'd7, 5'd7, 32'd8, 32'd8, 0);
  endtask

  task automatic test_reset_in_read();
    i_rd_rsp_ready = 1'b1;
    i_rd_req_valid = 1'b1; i_rs1 = 5'd1; i_rs2 = 5'd2;
    @(negedge clk);
    adv();
    i_rd_req_valid = 1'b0;
    adv();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (o_rd_rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rd_valid got=%0b want=0", o_rd_rsp_valid); end
    adv();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (o_rd_rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rd_no_rsp cyc%0d got=%0b want=0", k, o_rd_rsp_valid); end
      adv();
    end
    do_read(5'd2, 5'd3, 32'd3, 32'd4, 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    force_ones = 1'b0;
    rst = 1'b1;
    i_wr_valid = 1'b0; i_wr_addr = '0; i_wr_data = '0;
    i_rd_req_valid = 1'b0; i_rs1 = '0; i_rs2 = '0;
    i_rd_rsp_ready = 1'b1;
    test_reset();
    test_fill_and_read();
    test_write_priority();
    test_x0();
    test_stall();
    test_reset_in_write();
    test_reset_in_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
